// File: rtl/miniRISC_pkg.sv
// Shared miniRISC constants and the dmem_reader FSM state encoding.
package miniRISC_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } dmem_rd_state_t;

endpackage

// File: rtl/dmem_reader_fifo.sv
// Synchronous power-of-two FIFO holding {addr, data} entries for dmem_reader.
// The head is read combinationally from storage, so it stays put until popped.
module dmem_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_reader.sv
// Sequential BRAM read engine: sweeps [base_addr, base_addr+len) through a
// synchronous read port and streams {addr, data} over valid/ready.
// Optional build macro: DMEM_READER_CHECK_EN adds err_cnt, counting popped
// words that differ from their zero-extended address.
//
// Handshake: a word transfers in any cycle where out_valid && out_ready; while
// out_valid is high and out_ready low, out_data/out_addr are held unchanged.
// Reads are issued only while fifo_count + inflight < FIFO_DEPTH, so every
// returning word has a guaranteed FIFO slot.
module dmem_reader
    import miniRISC_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = miniRISC_pkg::DATA_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     len,
    output logic                busy,
    output logic                done,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W-1:0]   out_addr,
    output dmem_rd_state_t      dbg_state
`ifdef DMEM_READER_CHECK_EN
    ,
    output logic [15:0]         err_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dmem_rd_state_t              r_state;
    logic [ADDR_W-1:0]           r_addr;
    logic [ADDR_W:0]             r_rem;
    logic                        r_busy;
    logic                        r_done;
    logic [RD_LAT-1:0]           r_pipe_vld;
    logic [RD_LAT-1:0][ADDR_W-1:0] r_pipe_addr;

    logic [CW-1:0]               w_inflight;
    logic [CW-1:0]               w_fifo_count;
    logic                        w_fifo_empty;
    logic                        w_fifo_full;
    logic [ADDR_W+DATA_W-1:0]    w_head;
    logic                        w_issue;
    logic                        w_pop;
    logic                        w_drain;

    // Number of reads issued whose data has not yet reached the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe_vld[i]);
        end
    end

    assign w_issue = (r_state == READ) && (r_rem != '0) && !w_fifo_full &&
                     (({1'b0, w_fifo_count} + {1'b0, w_inflight}) < (CW+1)'(FIFO_DEPTH));
    assign w_pop   = !w_fifo_empty && out_ready;
    // Everything is drained once nothing is in flight and the FIFO empties this cycle.
    assign w_drain = (w_inflight == '0) &&
                     ((w_fifo_count == '0) || ((w_fifo_count == CW'(1)) && w_pop));

    // Sweep control FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_addr  <= base_addr;
                        r_rem   <= len;
                        r_busy  <= 1'b1;
                        r_state <= (len != '0) ? READ : FLUSH;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_rem  <= r_rem - (ADDR_W+1)'(1);
                        if (r_rem == (ADDR_W+1)'(1)) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_drain) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read-latency pipe carrying the valid flag and address tag of each read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld  <= '0;
            r_pipe_addr <= '0;
        end else begin
            r_pipe_vld[0]  <= w_issue;
            r_pipe_addr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    dmem_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_pipe_vld[RD_LAT-1]),
        .pop   (w_pop),
        .wdata ({r_pipe_addr[RD_LAT-1], mem_dout}),
        .head  (w_head),
        .count (w_fifo_count),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign busy                 = r_busy;
    assign done                 = r_done;
    assign mem_en               = w_issue;
    assign mem_addr             = r_addr;
    assign out_valid            = !w_fifo_empty;
    assign {out_addr, out_data} = w_head;
    assign dbg_state            = r_state;

`ifdef DMEM_READER_CHECK_EN
    logic [15:0]       r_err_cnt;
    logic [DATA_W-1:0] w_exp_data;

    assign w_exp_data = DATA_W'(out_addr);
    assign err_cnt    = r_err_cnt;

    // Saturating count of popped words that differ from their zero-extended address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_err_cnt <= '0;
        end else if (w_pop && (out_data != w_exp_data) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_reader.sv
// Scoreboard bench for dmem_reader: two instances (RD_LAT=1 and RD_LAT=2) share
// stimulus; each has its own BRAM read model, expected queue and monitor.
module tb_dmem_reader;
  import miniRISC_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TW = AW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len       = '0;
  logic          out_ready = 1'b1;

  logic [DW-1:0] mem [1024];

  logic a_busy, a_done, a_mem_en, a_out_valid;
  logic [AW-1:0] a_mem_addr, a_out_addr;
  logic [DW-1:0] a_mem_dout, a_out_data;
  dmem_rd_state_t a_state;
  logic b_busy, b_done, b_mem_en, b_out_valid;
  logic [AW-1:0] b_mem_addr, b_out_addr;
  logic [DW-1:0] b_mem_dout, b_out_data, b_q1;
  dmem_rd_state_t b_state;
`ifdef DMEM_READER_CHECK_EN
  logic [15:0] a_err_cnt, b_err_cnt;
`endif

  dmem_reader #(.RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(a_busy), .done(a_done), .mem_en(a_mem_en), .mem_addr(a_mem_addr),
    .mem_dout(a_mem_dout), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_addr(a_out_addr), .dbg_state(a_state)
`ifdef DMEM_READER_CHECK_EN
    , .err_cnt(a_err_cnt)
`endif
  );

  dmem_reader #(.RD_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(b_busy), .done(b_done), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
    .mem_dout(b_mem_dout), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_addr(b_out_addr), .dbg_state(b_state)
`ifdef DMEM_READER_CHECK_EN
    , .err_cnt(b_err_cnt)
`endif
  );

  // BRAM read models: one and two cycles of latency
  always @(posedge clk) begin
    if (a_mem_en) a_mem_dout <= mem[a_mem_addr];
    if (b_mem_en) b_q1 <= mem[b_mem_addr];
    b_mem_dout <= b_q1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard queues and monitors
  logic [TW-1:0] exp_a_q[$];
  logic [TW-1:0] exp_b_q[$];
  logic          a_hold = 1'b0, b_hold = 1'b0;
  logic [TW-1:0] a_held, b_held;

  always @(negedge clk) begin
    if (rst) begin
      a_hold = 1'b0;
    end else begin
      if (a_hold && a_out_valid) chk("a_hold_stable", {a_out_addr, a_out_data}, a_held);
      if (a_out_valid && out_ready) begin
        if (exp_a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra_word: got %0h expected none", {a_out_addr, a_out_data});
        end else begin
          chk("a_word", {a_out_addr, a_out_data}, exp_a_q.pop_front());
        end
      end
      a_hold = a_out_valid && !out_ready;
      a_held = {a_out_addr, a_out_data};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_hold = 1'b0;
    end else begin
      if (b_hold && b_out_valid) chk("b_hold_stable", {b_out_addr, b_out_data}, b_held);
      if (b_out_valid && out_ready) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_word: got %0h expected none", {b_out_addr, b_out_data});
        end else begin
          chk("b_word", {b_out_addr, b_out_data}, exp_b_q.pop_front());
        end
      end
      b_hold = b_out_valid && !out_ready;
      b_held = {b_out_addr, b_out_data};
    end
  end

  // per-sweep observations
  int a_done_rel, b_done_rel, a_first, b_first, a_last, b_last;
  int a_issues, b_issues, b_stalls;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_reset"}, {a_busy, a_done, a_mem_en, a_mem_addr, a_out_valid, a_out_addr, a_out_data}, '0);
    chk({tag, "_b_reset"}, {b_busy, b_done, b_mem_en, b_mem_addr, b_out_valid, b_out_addr, b_out_data}, '0);
    chk({tag, "_state"}, {a_state, b_state}, {IDLE, IDLE});
  endtask

  // driver: issues one start (called at #1 after a posedge) and runs until both instances pulse done
  task automatic run_sweep(input logic [AW-1:0] base_i, input logic [AW:0] len_i, input int mode);
    logic [AW-1:0] ad;
    int b_iss_tot, b_pop_tot;
    bit seen;
    for (int i = 0; i < int'(len_i); i++) begin
      ad = base_i + AW'(i);
      exp_a_q.push_back({ad, mem[ad]});
      exp_b_q.push_back({ad, mem[ad]});
    end
    a_done_rel = -1; b_done_rel = -1; a_first = -1; b_first = -1; a_last = -1; b_last = -1;
    a_issues = 0; b_issues = 0; b_stalls = 0; b_iss_tot = 0; b_pop_tot = 0; seen = 0;
    start = 1'b1; base_addr = base_i; len = len_i;
    for (int rel = 0; rel < 300; rel++) begin
      out_ready = (mode == 0) ? 1'b1 : ((rel % 4 == 0) || (rel % 4 == 3));
      @(negedge clk);
      if (rel == 1) begin
        chk("busy_after_start", {a_busy, b_busy}, 2'b11);
        if (len_i != 0) chk("first_issue_addr", {a_mem_en, a_mem_addr, b_mem_en, b_mem_addr},
                            {1'b1, base_i, 1'b1, base_i});
      end
      if (b_iss_tot - b_pop_tot >= 4) begin
        chk("b_credit_stall", b_mem_en, 0);
        b_stalls++;
      end
      if (b_iss_tot - b_pop_tot > 4) chk("b_credit_bound", b_iss_tot - b_pop_tot, 4);
      a_issues += int'(a_mem_en);
      b_issues += int'(b_mem_en);
      b_iss_tot += int'(b_mem_en);
      if (b_out_valid && out_ready) b_pop_tot++;
      if (a_out_valid && out_ready) begin
        if (a_first < 0) a_first = rel;
        a_last = rel;
      end
      if (b_out_valid && out_ready) begin
        if (b_first < 0) b_first = rel;
        b_last = rel;
      end
      if (a_done && a_done_rel < 0) a_done_rel = rel;
      if (b_done && b_done_rel < 0) b_done_rel = rel;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (a_done_rel >= 0 && b_done_rel >= 0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: got done_a=%0d done_b=%0d expected both done", a_done_rel, b_done_rel);
    end
    chk("a_issue_count", a_issues, len_i);
    chk("b_issue_count", b_issues, len_i);
    chk("queues_drained", exp_a_q.size() + exp_b_q.size(), 0);
  endtask

  // timing with out_ready held high
  task automatic check_timing(input int n);
    if (n == 0) begin
      chk("len0_done_cycle", {a_done_rel[7:0], b_done_rel[7:0]}, {8'd2, 8'd2});
    end else begin
      chk("a_done_cycle", a_done_rel, n + 3);
      chk("b_done_cycle", b_done_rel, n + 4);
      chk("a_first_pop", a_first, 3);
      chk("b_first_pop", b_first, 4);
      chk("a_last_pop", a_last, n + 2);
      chk("b_last_pop", b_last, n + 3);
    end
  endtask

  initial begin
    int dones;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_sweep(10'd0, 11'd8, 0);
    check_timing(8);
    run_sweep(10'd1022, 11'd4, 0);
    check_timing(4);
    run_sweep(10'd40, 11'd16, 1);
    chk("b_stall_seen", b_stalls > 0, 1);
    run_sweep(10'd0, 11'd0, 0);
    check_timing(0);
    run_sweep(10'd100, 11'd2, 0);
    check_timing(2);

    // reset in cycle 5 of a len=16 sweep
    for (int i = 0; i < 16; i++) begin
      exp_a_q.push_back({AW'(300 + i), mem[300 + i]});
      exp_b_q.push_back({AW'(300 + i), mem[300 + i]});
    end
    start = 1'b1; base_addr = 10'd300; len = 11'd16; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      dones += int'(a_done) + int'(b_done) + int'(a_mem_en) + int'(b_mem_en) + int'(a_out_valid) + int'(b_out_valid);
    end
    chk("midrst_quiet", dones, 0);
    @(posedge clk); #1;
    run_sweep(10'd500, 11'd5, 0);
    check_timing(5);

`ifdef DMEM_READER_CHECK_EN
    chk("err_cnt_clean", {a_err_cnt, b_err_cnt}, 32'd0);
    mem[5] = 32'hDEAD_BEEF;
    run_sweep(10'd0, 11'd8, 0);
    chk("err_cnt_one", {a_err_cnt, b_err_cnt}, {16'd1, 16'd1});
    mem[5] = 32'd5;
    run_sweep(10'd0, 11'd3, 0);
    chk("err_cnt_cleared", {a_err_cnt, b_err_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
